// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and defaults for the Huffman encoder control path.
//   huff_phase_t : phase encoding of the top-level scheduler
//   NSYM_DEF     : default alphabet size (histogram entries)
//   CNT_W_DEF    : default width of one histogram count
//   sym_t        : one entry of the symbol stream (idx, freq, last)
package huffman_pkg;

  localparam int unsigned NSYM_DEF  = 128;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned IDX_W_DEF = $clog2(NSYM_DEF);

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_CLEAR,
    PH_COUNT,
    PH_SCAN,
    PH_BUILD,
    PH_ENCODE,
    PH_DONE,
    PH_ERR
  } huff_phase_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic [CNT_W_DEF-1:0] freq;
    logic                 last;
  } sym_t;

endpackage

// File: rtl/huffman_sched_nz_scan.sv
// huff_nz_scan: combinational view of which histogram entries are non-zero.
//   curr_count_i : flattened histogram, entry i at [i*CNT_W +: CNT_W]
//   idx_i        : current scan index
//   nz_mask_o    : bit i set when entry i is non-zero
//   above_nz_o   : some entry strictly above idx_i is non-zero
//   all_zero_o   : every entry is zero
module huff_nz_scan
  import huffman_pkg::*;
#(
  parameter int unsigned NSYM  = NSYM_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic [NSYM*CNT_W-1:0]   curr_count_i,
  input  logic [$clog2(NSYM)-1:0] idx_i,
  output logic [NSYM-1:0]         nz_mask_o,
  output logic                    above_nz_o,
  output logic                    all_zero_o
);

  logic [NSYM-1:0] above_mask;

  always_comb begin
    nz_mask_o = '0;
    for (int unsigned i = 0; i < NSYM; i++) begin
      nz_mask_o[i] = |curr_count_i[i*CNT_W +: CNT_W];
    end
  end

  // Drop entries 0..idx_i so only the strictly-higher ones remain.
  assign above_mask = (nz_mask_o >> idx_i) >> 1;
  assign above_nz_o = |above_mask;
  assign all_zero_o = ~|nz_mask_o;

endmodule

// File: rtl/huffman_sched.sv
// huffman_sched: top-level phase sequencer of the Huffman encoder.
// Drives clear/count of the frequency read path, streams non-zero histogram
// entries to the tree builder, then waits for tree build and encode.
//   clk, reset (async, active low)
//   start_req, stop_req      : bus-side start pulse / abort request
//   count_done, curr_count   : read-path size flag and histogram
//   clear_out, read_en       : controls into the counting datapath
//   sym_valid/ready/idx/freq/last : symbol stream to the tree builder
//   tree_done, enc_start, enc_done: tree builder / encoder handshake
//   busy, done, err, nsym_used    : status (done/err sticky until start_req)
// Optional: define HUFF_SCHED_WDOG_EN to add a per-phase watchdog of
// WDOG_CYCLES cycles in COUNT, BUILD, ENCODE and on sym_ready stalls.
module huffman_sched
  import huffman_pkg::*;
#(
  parameter int unsigned NSYM        = NSYM_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_req,
  input  logic                    stop_req,
  input  logic                    count_done,
  input  logic [NSYM*CNT_W-1:0]   curr_count,
  output logic                    clear_out,
  output logic                    read_en,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic [$clog2(NSYM)-1:0] sym_idx,
  output logic [CNT_W-1:0]        sym_freq,
  output logic                    sym_last,
  input  logic                    tree_done,
  output logic                    enc_start,
  input  logic                    enc_done,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [$clog2(NSYM):0]   nsym_used
);

  localparam int unsigned IDX_W = $clog2(NSYM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSYM - 1);

  huff_phase_t state_q, state_d;
  logic clear_q, clear_d, read_en_q, read_en_d, valid_q, valid_d;
  logic enc_start_q, enc_start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d, look_idx;
  logic [CNT_W-1:0] freq_q, freq_d, look_freq;
  logic [IDX_W:0]   nsym_q, nsym_d;
  logic [NSYM-1:0]  nz_mask;
  logic above_nz, all_zero, look_nz, abortable, wdog_trip;

  huff_nz_scan #(.NSYM(NSYM), .CNT_W(CNT_W)) u_nz_scan (
    .curr_count_i (curr_count),
    .idx_i        (idx_q),
    .nz_mask_o    (nz_mask),
    .above_nz_o   (above_nz),
    .all_zero_o   (all_zero)
  );

  // Registered valid/freq are loaded one entry ahead: entry 0 on leaving
  // COUNT, entry idx+1 while scanning, keeping one entry per cycle.
  assign look_idx  = (state_q == PH_SCAN) ? idx_q + 1'b1 : '0;
  assign look_nz   = nz_mask[look_idx];
  assign look_freq = curr_count[look_idx*CNT_W +: CNT_W];
  assign abortable = state_q inside {PH_CLEAR, PH_COUNT, PH_SCAN, PH_BUILD, PH_ENCODE};

`ifdef HUFF_SCHED_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic watched;

  assign watched = (state_q inside {PH_COUNT, PH_BUILD, PH_ENCODE}) ||
                   ((state_q == PH_SCAN) && valid_q && !sym_ready);
  assign wdog_trip = watched && (wdog_q == WD_W'(WDOG_CYCLES - 1));
  // Restarts whenever the phase changes or a stall ends.
  assign wdog_d = (watched && (state_d == state_q)) ? wdog_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic wdog_unused;
  assign wdog_trip   = 1'b0;
  assign wdog_unused = (WDOG_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    clear_d     = 1'b0;
    read_en_d   = 1'b0;
    valid_d     = valid_q;
    idx_d       = idx_q;
    freq_d      = freq_q;
    enc_start_d = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    nsym_d      = nsym_q;

    case (state_q)
      PH_IDLE, PH_DONE, PH_ERR: begin
        if (start_req) begin
          state_d = PH_CLEAR;
          clear_d = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          nsym_d  = '0;
        end
      end
      PH_CLEAR: begin
        state_d   = PH_COUNT;
        read_en_d = 1'b1;
      end
      PH_COUNT: begin
        if (count_done) begin
          state_d = PH_SCAN;
          idx_d   = '0;
          valid_d = look_nz;
          freq_d  = look_freq;
        end else begin
          read_en_d = 1'b1;
        end
      end
      PH_SCAN: begin
        if (valid_q && !sym_ready) begin
          // stalled: hold idx/freq/valid
        end else if (valid_q && !above_nz) begin
          nsym_d  = nsym_q + 1'b1;
          state_d = PH_BUILD;
          valid_d = 1'b0;
        end else if (!valid_q && (idx_q == IDX_LAST)) begin
          state_d = all_zero ? PH_ERR : PH_BUILD;
          err_d   = all_zero;
        end else begin
          if (valid_q) nsym_d = nsym_q + 1'b1;
          idx_d   = look_idx;
          valid_d = look_nz;
          freq_d  = look_freq;
        end
      end
      PH_BUILD: begin
        if (tree_done) begin
          state_d     = PH_ENCODE;
          enc_start_d = 1'b1;
        end
      end
      PH_ENCODE: begin
        if (enc_done) begin
          state_d = PH_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = PH_IDLE;
    endcase

    // Abort/watchdog override everything, including a transfer in this cycle.
    if ((stop_req && abortable) || wdog_trip) begin
      state_d     = PH_ERR;
      err_d       = 1'b1;
      clear_d     = 1'b0;
      read_en_d   = 1'b0;
      valid_d     = 1'b0;
      enc_start_d = 1'b0;
      idx_d       = idx_q;
      freq_d      = freq_q;
      nsym_d      = nsym_q;
      done_d      = done_q;
    end

    busy_d = !(state_d inside {PH_IDLE, PH_DONE, PH_ERR});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= PH_IDLE;
      clear_q     <= 1'b0;
      read_en_q   <= 1'b0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      freq_q      <= '0;
      enc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      nsym_q      <= '0;
    end else begin
      state_q     <= state_d;
      clear_q     <= clear_d;
      read_en_q   <= read_en_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      freq_q      <= freq_d;
      enc_start_q <= enc_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      nsym_q      <= nsym_d;
    end
  end

  assign clear_out = clear_q;
  assign read_en   = read_en_q;
  assign sym_valid = valid_q;
  assign sym_idx   = idx_q;
  assign sym_freq  = freq_q;
  assign sym_last  = valid_q & ~above_nz;
  assign enc_start = enc_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign nsym_used = nsym_q;

endmodule

// File: tb/tb_huffman_sched.sv
// tb_huffman_sched: self-checking bench for huffman_sched against a
// list-based model of the expected symbol stream and scan timing.
module tb_huffman_sched;
  import huffman_pkg::*;

  localparam int unsigned NSYM  = 128;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_req = 1'b0, stop_req = 1'b0, count_done = 1'b0;
  logic sym_ready = 1'b0, tree_done = 1'b0, enc_done = 1'b0;
  logic [NSYM*CNT_W-1:0] curr_count = '0;
  logic clear_out, read_en, sym_valid, sym_last, enc_start, busy, done, err;
  logic [IDX_W-1:0] sym_idx;
  logic [CNT_W-1:0] sym_freq;
  logic [IDX_W:0]   nsym_used;

  int total = 0;
  int bad = 0;
  int unsigned hist [NSYM];

  always #5 clk = ~clk;

  huffman_sched #(.NSYM(NSYM), .CNT_W(CNT_W), .WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req),
    .count_done(count_done), .curr_count(curr_count), .clear_out(clear_out),
    .read_en(read_en), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_idx(sym_idx), .sym_freq(sym_freq), .sym_last(sym_last),
    .tree_done(tree_done), .enc_start(enc_start), .enc_done(enc_done),
    .busy(busy), .done(done), .err(err), .nsym_used(nsym_used)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_hist();
    for (int i = 0; i < NSYM; i++) curr_count[i*CNT_W +: CNT_W] = CNT_W'(hist[i]);
  endtask

  task automatic clear_hist();
    for (int i = 0; i < NSYM; i++) hist[i] = 0;
  endtask

  task automatic gen_hist(input int unsigned pct);
    for (int i = 0; i < NSYM; i++)
      hist[i] = ($urandom_range(0, 99) < pct) ? $urandom_range(1, 65535) : 0;
    hist[$urandom_range(0, NSYM-1)] = $urandom_range(1, 65535);
    load_hist();
  endtask

  task automatic start_job();
    @(negedge clk); start_req = 1'b1;
    @(negedge clk); start_req = 1'b0;
    check("clear_pulse", clear_out, 1);
    check("start_done_clr", done, 0);
    check("start_err_clr", err, 0);
    check("start_nsym_clr", nsym_used, 0);
    check("start_busy", busy, 1);
    @(negedge clk);
    check("clear_one_cycle", clear_out, 0);
    check("read_en_on", read_en, 1);
  endtask

  task automatic count_phase(input int unsigned n);
    repeat (n) begin
      check("read_en_hold", read_en, 1);
      @(negedge clk);
    end
    count_done = 1'b1;
    @(negedge clk); count_done = 1'b0;
    check("read_en_off", read_en, 0);
  endtask

  // Model: expected stream is the ordered list of non-zero entries; scan
  // length is (highest non-zero index + 1 + stall cycles), or NSYM if none.
  task automatic run_scan(input int unsigned stall_first, input bit rand_stall);
    sym_t exp_q[$];
    sym_t s;
    int unsigned cycles = 0, stalls = 0, run = 0, got = 0, last_nz = 0;
    for (int unsigned i = 0; i < NSYM; i++) begin
      if (hist[i] != 0) begin
        s.idx = IDX_W'(i); s.freq = CNT_W'(hist[i]); s.last = 1'b0;
        exp_q.push_back(s);
        last_nz = i;
      end
    end
    if (exp_q.size() != 0) exp_q[exp_q.size()-1].last = 1'b1;
    while (1) begin
      if (exp_q.size() == 0 && err) break;
      if (exp_q.size() != 0 && got == exp_q.size()) break;
      if (cycles > NSYM + 64) begin
        if (exp_q.size() == 0) check("scan_budget_err", err, 1);
        else check("scan_budget_xfer", got, exp_q.size());
        break;
      end
      cycles++;
      if (sym_valid) begin
        if (got >= exp_q.size()) begin
          check("extra_valid", sym_valid, 0);
          sym_ready = 1'b1;
        end else begin
          check("sym_idx", sym_idx, exp_q[got].idx);
          check("sym_freq", sym_freq, exp_q[got].freq);
          check("sym_last", sym_last, exp_q[got].last);
          if ((got == 0) ? (run < stall_first)
                         : (rand_stall && run < 3 && $urandom_range(0, 3) == 0)) begin
            run++; stalls++; sym_ready = 1'b0;
          end else begin
            got++; run = 0; sym_ready = 1'b1;
          end
        end
      end else begin
        sym_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    sym_ready = 1'b0;
    check("scan_cycles", cycles, (exp_q.size() == 0) ? NSYM : last_nz + 1 + stalls);
    check("nsym_used", nsym_used, exp_q.size());
    if (exp_q.size() == 0) begin
      check("zero_err", err, 1);
      check("zero_busy", busy, 0);
    end else begin
      check("build_valid_low", sym_valid, 0);
      check("build_busy", busy, 1);
      check("build_err", err, 0);
    end
  endtask

  task automatic finish_job(input int unsigned tree_dly, input int unsigned enc_dly);
    repeat (tree_dly) begin
      @(negedge clk);
      check("no_early_enc", enc_start, 0);
    end
    tree_done = 1'b1;
    @(negedge clk); tree_done = 1'b0;
    check("enc_start", enc_start, 1);
    @(negedge clk);
    check("enc_start_pulse", enc_start, 0);
    repeat (enc_dly) @(negedge clk);
    check("done_wait", done, 0);
    enc_done = 1'b1;
    @(negedge clk); enc_done = 1'b0;
    check("done_set", done, 1);
    check("done_busy", busy, 0);
    check("done_err", err, 0);
  endtask

  initial begin
    int unsigned n;
    repeat (2) @(negedge clk);
    check("rst_clear", clear_out, 0);
    check("rst_read_en", read_en, 0);
    check("rst_valid", sym_valid, 0);
    check("rst_last", sym_last, 0);
    check("rst_idx", sym_idx, 0);
    check("rst_freq", sym_freq, 0);
    check("rst_enc", enc_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_nsym", nsym_used, 0);
    reset = 1'b1;

    // Two symbols: (3,5) then (65,2,last)
    clear_hist(); hist[3] = 5; hist[65] = 2; load_hist();
    start_job(); count_phase(3); run_scan(0, 1'b0); finish_job(2, 3);

    // All-zero histogram
    clear_hist(); load_hist();
    start_job(); count_phase(2); run_scan(0, 1'b0);

    // Single symbol at the top index
    clear_hist(); hist[127] = 1; load_hist();
    start_job(); count_phase(1); run_scan(0, 1'b0); finish_job(0, 0);

    // First symbol stalled for 5 cycles
    gen_hist(10);
    start_job(); count_phase(2); run_scan(5, 1'b0); finish_job(1, 1);

    // Random histograms with random backpressure
    for (int r = 0; r < 4; r++) begin
      gen_hist(5 + r * 10);
      start_job(); count_phase($urandom_range(0, 4));
      run_scan($urandom_range(0, 3), 1'b1);
      finish_job($urandom_range(0, 4), $urandom_range(0, 4));
    end

    // Abort during COUNT, then restart
    start_job();
    repeat (2) @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk); stop_req = 1'b0;
    check("stop_cnt_read_en", read_en, 0);
    check("stop_cnt_err", err, 1);
    check("stop_cnt_busy", busy, 0);

    // Restart clears err; abort in SCAN with a transfer offered
    clear_hist(); hist[10] = 7; hist[20] = 9; load_hist();
    start_job(); count_phase(1);
    n = 0;
    while (!sym_valid && n < NSYM + 4) begin @(negedge clk); n++; end
    check("stop_scan_valid", sym_valid, 1);
    check("stop_scan_idx", sym_idx, 10);
    stop_req = 1'b1; sym_ready = 1'b1;
    @(negedge clk); stop_req = 1'b0; sym_ready = 1'b0;
    check("stop_scan_valid_off", sym_valid, 0);
    check("stop_scan_err", err, 1);
    check("stop_scan_nsym", nsym_used, 0);
    check("stop_scan_last", sym_last, 0);

    // tree_done and stop_req together: abort wins
    gen_hist(8);
    start_job(); count_phase(1); run_scan(0, 1'b0);
    tree_done = 1'b1; stop_req = 1'b1;
    @(negedge clk); tree_done = 1'b0; stop_req = 1'b0;
    check("tie_enc_start", enc_start, 0);
    check("tie_err", err, 1);
    @(negedge clk);
    check("tie_enc_start_late", enc_start, 0);

    // Asynchronous reset mid-COUNT
    start_job();
    @(negedge clk); #2 reset = 1'b0; #1;
    check("arst_read_en", read_en, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    @(negedge clk); reset = 1'b1;

`ifdef HUFF_SCHED_WDOG_EN
    // tree_done never arrives: watchdog fires 16 cycles into BUILD
    gen_hist(10);
    start_job(); count_phase(1); run_scan(0, 1'b0);
    n = 0;
    while (!err && n < 100) begin @(negedge clk); n++; end
    check("wdog_build_cycles", n, 16);
    check("wdog_err", err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
